// File: rtl/construtor_caminho_pkg.sv
// construtor_caminho_pkg: walk FSM state encoding, default sizes and estabelecidos entry layout
package construtor_caminho_pkg;
  localparam int CC_ADDR_WIDTH = 6;
  localparam int CC_DATA_WIDTH = 8;
  localparam int CC_MAX_PASSOS = 64;
  typedef enum logic [2:0] {OCIOSO, ENVIAR, LER, ESPERAR, FIM, ERRO} estado_t;
  function automatic int est_flag_bit(input int data_width);
    return data_width - 1;
  endfunction
endpackage

// File: rtl/construtor_caminho.sv
// construtor_caminho: walks anterior pointers from destino to fonte and streams each node; optional CAMINHO_PASSOS_EN adds a hop-count port
module construtor_caminho
  import construtor_caminho_pkg::*;
#(
  parameter int ADDR_WIDTH = CC_ADDR_WIDTH,
  parameter int DATA_WIDTH = CC_DATA_WIDTH,
  parameter int MAX_PASSOS = CC_MAX_PASSOS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar_in,
  input  logic [ADDR_WIDTH-1:0] fonte_in,
  input  logic [ADDR_WIDTH-1:0] destino_in,
  output logic                  read_en_out,
  output logic [ADDR_WIDTH-1:0] read_addr_out,
  input  logic [DATA_WIDTH-1:0] read_data_in,
  output logic                  caminho_valid_out,
  output logic [ADDR_WIDTH-1:0] caminho_addr_out,
  output logic                  caminho_ultimo_out,
  input  logic                  lido_in,
  output logic                  caminho_pronto_out,
  output logic                  erro_out,
`ifdef CAMINHO_PASSOS_EN
  output logic [$clog2(MAX_PASSOS):0] caminho_passos_out,
`endif
  output logic                  ocupado_out
);
  localparam int PW = $clog2(MAX_PASSOS);
  localparam int EST_FLAG_BIT = est_flag_bit(DATA_WIDTH);
  estado_t estado_q, estado_d;
  logic [ADDR_WIDTH-1:0] atual_q, atual_d, fonte_q, fonte_d;
  logic [PW-1:0] passos_q, passos_d;
  logic erro_q, erro_d;
  logic inicio, no_fonte, estabelecido, limite, unused_bits;
  assign inicio = estado_q == OCIOSO && iniciar_in;
  assign no_fonte = atual_q == fonte_q;
  assign estabelecido = read_data_in[EST_FLAG_BIT];
  assign limite = passos_q == PW'(MAX_PASSOS - 1);
  assign unused_bits = &{1'b0, read_data_in};
  // state and walk registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= OCIOSO;
      atual_q  <= '0;
      fonte_q  <= '0;
      passos_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      atual_q  <= atual_d;
      fonte_q  <= fonte_d;
      passos_q <= passos_d;
      erro_q   <= erro_d;
    end
  end
  // next state: hop limit is checked on acceptance so the counter never wraps
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  estado_d = iniciar_in ? ENVIAR : OCIOSO;
      ENVIAR:  estado_d = !lido_in ? ENVIAR : no_fonte ? FIM : limite ? ERRO : LER;
      LER:     estado_d = ESPERAR;
      ESPERAR: estado_d = estabelecido ? ENVIAR : ERRO;
      default: estado_d = OCIOSO;
    endcase
  end
  // walk datapath: latch on start, follow anterior after each established read
  always_comb begin
    atual_d  = inicio ? destino_in : (estado_q == ESPERAR && estabelecido) ? read_data_in[ADDR_WIDTH-1:0] : atual_q;
    fonte_d  = inicio ? fonte_in : fonte_q;
    passos_d = inicio ? '0 : (estado_q == ESPERAR && estabelecido) ? passos_q + PW'(1) : passos_q;
    erro_d   = inicio ? 1'b0 : estado_q == ERRO ? 1'b1 : erro_q;
  end
  // outputs decoded from state and registers only
  always_comb begin
    caminho_valid_out  = estado_q == ENVIAR;
    caminho_addr_out   = estado_q == ENVIAR ? atual_q : '0;
    caminho_ultimo_out = estado_q == ENVIAR && no_fonte;
    read_en_out        = estado_q == LER;
    read_addr_out      = estado_q == LER ? atual_q : '0;
    caminho_pronto_out = estado_q == FIM;
    erro_out           = erro_q;
    ocupado_out        = estado_q != OCIOSO;
  end
`ifdef CAMINHO_PASSOS_EN
  assign caminho_passos_out = {1'b0, passos_q};
`endif
endmodule
